// File: rtl/ttc3_pkg.sv
// Shared types and widths for the HMAC tag verifier.
package ttc3_pkg;

  localparam int TAG_W = 256;
  localparam int MSG_W = 256;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    WAIT    = 3'd2,
    COMPARE = 3'd3,
    ZEROIZE = 3'd4,
    REPORT  = 3'd5
  } vrfy_state_e;

  function automatic logic state_is_legal(vrfy_state_e s);
    logic ok;
    ok = 1'b0;
    case (s)
      IDLE, LAUNCH, WAIT, COMPARE, ZEROIZE, REPORT: ok = 1'b1;
      default:                                      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ttc3_ct_compare.sv
// Constant-time tag compare: walks every slice once per run, no data-dependent control.
module ttc3_ct_compare
  import ttc3_pkg::*;
#(
  parameter int CMP_WORDS = 8
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             force_i,
  input  logic             run_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic [TAG_W-1:0] exp_i,
  output logic             diff_o,
  output logic             last_o
);

  localparam int SLICE_W = TAG_W / CMP_WORDS;
  localparam int IDX_W   = (CMP_WORDS > 1) ? $clog2(CMP_WORDS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CMP_WORDS - 1);

  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               diff_q, diff_d;
  logic [SLICE_W-1:0] tag_w [CMP_WORDS];
  logic [SLICE_W-1:0] exp_w [CMP_WORDS];
  logic               slice_ne;

  always_comb begin
    for (int i = 0; i < CMP_WORDS; i++) begin
      tag_w[i] = tag_i[i*SLICE_W +: SLICE_W];
      exp_w[i] = exp_i[i*SLICE_W +: SLICE_W];
    end
  end

  assign slice_ne = |(tag_w[idx_q] ^ exp_w[idx_q]);
  assign last_o   = (idx_q == IDX_LAST);
  assign diff_o   = diff_q;

  always_comb begin
    idx_d  = idx_q;
    diff_d = diff_q;
    if (clear_i) begin
      idx_d  = '0;
      diff_d = 1'b0;
    end else if (force_i) begin
      diff_d = 1'b1;
    end else if (run_i) begin
      diff_d = diff_q | slice_ne;
      idx_d  = last_o ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      idx_q  <= '0;
      diff_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      diff_q <= diff_d;
    end
  end

endmodule

// File: rtl/ttc3_hmac_verify.sv
// HMAC tag verifier: launches one HMAC, compares the tag in constant time, tracks failures.
//   state   | meaning
//   IDLE    | waiting for vrfy_start
//   LAUNCH  | waiting for engine idle, pulses hmac_start
//   WAIT    | waiting for hmac_done, timeout timer running
//   COMPARE | CMP_WORDS slice compares
//   ZEROIZE | wipe captured data, latch result, update fail counter
//   REPORT  | vrfy_done pulse
module ttc3_hmac_verify
  import ttc3_pkg::*;
#(
  parameter int MAX_FAILS   = 3,
  parameter int CNT_W       = 4,
  parameter int CMP_WORDS   = 8,
  parameter int TIMEOUT_CYC = 512
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             vrfy_start_i,
  input  logic [MSG_W-1:0] vrfy_message_i,
  input  logic [TAG_W-1:0] vrfy_expected_i,
  output logic             vrfy_busy_o,
  output logic             vrfy_done_o,
  output logic             vrfy_pass_o,
  output logic             vrfy_locked_o,
  output logic [CNT_W-1:0] fail_count_o,
  output logic             hmac_start_o,
  output logic [MSG_W-1:0] hmac_message_o,
  input  logic             hmac_busy_i,
  input  logic             hmac_done_i,
  input  logic [TAG_W-1:0] hmac_tag_i
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_END  = TMR_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] FAIL_MAX = CNT_W'(MAX_FAILS);

  vrfy_state_e      state_q;
  logic [MSG_W-1:0] msg_q;
  logic [TAG_W-1:0] exp_q;
  logic [TAG_W-1:0] tag_q;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             locked_q;
  logic             done_q;
  logic             pass_q;
  logic             hstart_q;

  logic cmp_clear, cmp_force, cmp_run, cmp_diff, cmp_last;
  logic timeout, illegal;

  assign timer_d    = timer_q + 1'b1;
  assign fail_cnt_d = (fail_cnt_q >= FAIL_MAX) ? fail_cnt_q : fail_cnt_q + 1'b1;
  assign timeout    = (state_q == WAIT) && !hmac_done_i && (timer_d == TMR_END);
  assign illegal    = !state_is_legal(state_q);

  assign cmp_clear = ((state_q == WAIT) && hmac_done_i) || (state_q == REPORT);
  assign cmp_force = timeout || illegal;
  assign cmp_run   = (state_q == COMPARE);

  ttc3_ct_compare #(
    .CMP_WORDS (CMP_WORDS)
  ) u_cmp (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .clear_i (cmp_clear),
    .force_i (cmp_force),
    .run_i   (cmp_run),
    .tag_i   (tag_q),
    .exp_i   (exp_q),
    .diff_o  (cmp_diff),
    .last_o  (cmp_last)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      msg_q      <= '0;
      exp_q      <= '0;
      tag_q      <= '0;
      timer_q    <= '0;
      fail_cnt_q <= '0;
      locked_q   <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      hstart_q   <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      hstart_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (vrfy_start_i) begin
            if (locked_q) begin
              done_q  <= 1'b1;
              state_q <= REPORT;
            end else begin
              msg_q    <= vrfy_message_i;
              exp_q    <= vrfy_expected_i;
              hstart_q <= !hmac_busy_i;
              state_q  <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          // hstart_q is the visible launch pulse; the engine-idle check runs one cycle ahead of it
          if (hstart_q) begin
            timer_q <= '0;
            state_q <= WAIT;
          end else if (!hmac_busy_i) begin
            hstart_q <= 1'b1;
          end
        end
        WAIT: begin
          if (hmac_done_i) begin
            tag_q   <= hmac_tag_i;
            state_q <= COMPARE;
          end else begin
            timer_q <= timer_d;
            if (timer_d == TMR_END) begin
              tag_q   <= '0;
              state_q <= ZEROIZE;
            end
          end
        end
        COMPARE: begin
          if (cmp_last) state_q <= ZEROIZE;
        end
        ZEROIZE: begin
          msg_q   <= '0;
          exp_q   <= '0;
          tag_q   <= '0;
          timer_q <= '0;
          done_q  <= 1'b1;
          pass_q  <= !cmp_diff;
          if (!cmp_diff) begin
            fail_cnt_q <= '0;
          end else begin
            fail_cnt_q <= fail_cnt_d;
            if (fail_cnt_d >= FAIL_MAX) locked_q <= 1'b1;
          end
          state_q <= REPORT;
        end
        REPORT: begin
          state_q <= IDLE;
        end
        default: begin
          msg_q   <= '0;
          exp_q   <= '0;
          tag_q   <= '0;
          state_q <= ZEROIZE;
        end
      endcase
    end
  end

  assign vrfy_busy_o    = (state_q != IDLE);
  assign vrfy_done_o    = done_q;
  assign vrfy_pass_o    = pass_q;
  assign vrfy_locked_o  = locked_q;
  assign fail_count_o   = fail_cnt_q;
  assign hmac_start_o   = hstart_q;
  assign hmac_message_o = ((state_q == LAUNCH) || (state_q == WAIT)) ? msg_q : '0;

endmodule
